// File: rtl/ext_bus_responder_if.sv
// ext_bus_responder_if: external 16-bit bus pins plus the responder's
// word-wide SRAM port.
// Ports (signals):
//   IN_bus, IN_busActive       initiator -> responder bus data and strobe
//   OUT_bus, OUT_busOEn        responder -> initiator data and per-bit enable
//   OUT_busWait(OEn)           hold-off to the initiator and its enable
//   OUT_mem*, IN_memData       synchronous 32-bit SRAM port
// Modports: slave = responder view, master = initiator/SRAM-model view.
interface ext_bus_responder_if #(
    parameter int unsigned MEM_AW = 16
);
    logic [15:0]       IN_bus;
    logic              IN_busActive;
    logic [15:0]       OUT_bus;
    logic [15:0]       OUT_busOEn;
    logic              OUT_busWait;
    logic              OUT_busWaitOEn;
    logic [MEM_AW-1:0] OUT_memAddr;
    logic [31:0]       OUT_memData;
    logic [31:0]       IN_memData;
    logic              OUT_memCE;
    logic              OUT_memWE;
    logic [3:0]        OUT_memWM;

    modport slave (
        input  IN_bus, IN_busActive, IN_memData,
        output OUT_bus, OUT_busOEn, OUT_busWait, OUT_busWaitOEn,
        output OUT_memAddr, OUT_memData, OUT_memCE, OUT_memWE, OUT_memWM
    );

    modport master (
        output IN_bus, IN_busActive, IN_memData,
        input  OUT_bus, OUT_busOEn, OUT_busWait, OUT_busWaitOEn,
        input  OUT_memAddr, OUT_memData, OUT_memCE, OUT_memWE, OUT_memWM
    );
endinterface

// File: rtl/ext_bus_responder.sv
// ext_bus_responder: target side of the 16-bit external memory bus.
// Decodes a two-halfword address header, holds the initiator off with
// OUT_busWait, then sinks halfwords into (write) or streams halfwords out of
// (read) a 32-bit synchronous SRAM port.
// Ports:
//   clk       bus clock
//   rst       asynchronous reset, active low
//   bus       ext_bus_responder_if.slave: bus pins and SRAM port
//   OUT_busy  high whenever the responder is not idle
module ext_bus_responder #(
    parameter int unsigned WAIT_CYCLES = 4,
    parameter int unsigned MEM_AW      = 16
) (
    input  logic               clk,
    input  logic               rst,
    ext_bus_responder_if.slave bus,
    output logic               OUT_busy
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned HA_W  = 31;
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(WAIT_CYCLES - 1);
    localparam bit               EARLY_FETCH = (WAIT_CYCLES == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_LO,
        S_WAIT,
        S_READ,
        S_WRITE
    } state_e;

    state_e            state_q, state_d;
    logic              dir_q, dir_d;
    logic [14:0]       hdr0_q, hdr0_d;
    logic [HA_W-1:0]   haddr_q, haddr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rsel_q, rsel_d;
    logic              rsel_dly_q, rsel_dly_d;
    logic [15:0]       bus_q, bus_d;
    logic [15:0]       oen_q, oen_d;
    logic              wait_q, wait_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ce_q, ce_d;
    logic              we_q, we_d;
    logic [3:0]        wm_q, wm_d;
    logic              busy_q, busy_d;

    logic              fetch_c;
    logic [HA_W-1:0]   fetch_addr_c;
    logic [HA_W-1:0]   hdr_addr_c;
    logic [15:0]       rd_half_c;
    logic              fetch_window_c;

    // Halfword of the word returned for the read issued two edges ago
    assign rd_half_c  = rsel_dly_q ? bus.IN_memData[31:16] : bus.IN_memData[15:0];
    assign hdr_addr_c = {hdr0_q, bus.IN_bus};
    // Reads start two edges before busWait falls so data lands on that edge
    assign fetch_window_c = ((5'(cnt_q) + 5'd3) >= 5'(WAIT_CYCLES));

    // Next-state and output decode
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        hdr0_d       = hdr0_q;
        haddr_d      = haddr_q;
        cnt_d        = cnt_q;
        rsel_d       = rsel_q;
        rsel_dly_d   = rsel_q;
        bus_d        = bus_q;
        oen_d        = oen_q;
        wait_d       = wait_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        ce_d         = 1'b1;
        we_d         = 1'b1;
        wm_d         = 4'b0000;
        fetch_c      = 1'b0;
        fetch_addr_c = haddr_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.IN_busActive) begin
                    dir_d   = bus.IN_bus[15];
                    hdr0_d  = bus.IN_bus[14:0];
                    state_d = S_ADDR_LO;
                end
            end
            S_ADDR_LO: begin
                if (!bus.IN_busActive) begin
                    state_d = S_IDLE;
                end else begin
                    haddr_d = hdr_addr_c;
                    wait_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                    if (!dir_q && EARLY_FETCH) begin
                        fetch_c      = 1'b1;
                        fetch_addr_c = hdr_addr_c;
                        haddr_d      = hdr_addr_c + HA_W'(1);
                    end
                end
            end
            S_WAIT: begin
                if (!bus.IN_busActive) begin
                    wait_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!dir_q && fetch_window_c) begin
                        fetch_c = 1'b1;
                        haddr_d = haddr_q + HA_W'(1);
                    end
                    if (cnt_q == WAIT_LAST) begin
                        wait_d = 1'b0;
                        if (dir_q) begin
                            state_d = S_WRITE;
                        end else begin
                            state_d = S_READ;
                            oen_d   = 16'hffff;
                            bus_d   = rd_half_c;
                        end
                    end
                end
            end
            S_READ: begin
                if (!bus.IN_busActive) begin
                    oen_d   = 16'h0000;
                    state_d = S_IDLE;
                end else begin
                    bus_d   = rd_half_c;
                    fetch_c = 1'b1;
                    haddr_d = haddr_q + HA_W'(1);
                end
            end
            S_WRITE: begin
                if (!bus.IN_busActive) begin
                    state_d = S_IDLE;
                end else begin
                    ce_d    = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = MEM_AW'(haddr_q >> 1);
                    wm_d    = haddr_q[0] ? 4'b1100 : 4'b0011;
                    wdata_d = haddr_q[0] ? {bus.IN_bus, 16'h0000} : {16'h0000, bus.IN_bus};
                    haddr_d = haddr_q + HA_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Read issue shares the address register with writes
        if (fetch_c) begin
            ce_d   = 1'b0;
            we_d   = 1'b1;
            addr_d = MEM_AW'(fetch_addr_c >> 1);
            rsel_d = fetch_addr_c[0];
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            dir_q      <= 1'b0;
            hdr0_q     <= '0;
            haddr_q    <= '0;
            cnt_q      <= '0;
            rsel_q     <= 1'b0;
            rsel_dly_q <= 1'b0;
            bus_q      <= '0;
            oen_q      <= '0;
            wait_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ce_q       <= 1'b1;
            we_q       <= 1'b1;
            wm_q       <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            hdr0_q     <= hdr0_d;
            haddr_q    <= haddr_d;
            cnt_q      <= cnt_d;
            rsel_q     <= rsel_d;
            rsel_dly_q <= rsel_dly_d;
            bus_q      <= bus_d;
            oen_q      <= oen_d;
            wait_q     <= wait_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ce_q       <= ce_d;
            we_q       <= we_d;
            wm_q       <= wm_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.OUT_bus        = bus_q;
    assign bus.OUT_busOEn     = oen_q;
    assign bus.OUT_busWait    = wait_q;
    assign bus.OUT_busWaitOEn = 1'b1;
    assign bus.OUT_memAddr    = addr_q;
    assign bus.OUT_memData    = wdata_q;
    assign bus.OUT_memCE      = ce_q;
    assign bus.OUT_memWE      = we_q;
    assign bus.OUT_memWM      = wm_q;
    assign OUT_busy           = busy_q;
endmodule

// File: tb/tb_ext_bus_responder.sv
// tb_ext_bus_responder: drives one bus stimulus stream into two responders
// (16-bit and 4-bit SRAM word address) and scoreboards every SRAM write and
// every presented read halfword against a transaction-level memory model.
module tb_ext_bus_responder;
    localparam int unsigned W    = 4;
    localparam int unsigned AW_W = 16;
    localparam int unsigned AW_N = 4;

    typedef struct {
        bit          is_wr;
        int unsigned addr;
        logic [3:0]  wm;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy_w, busy_n;
    logic [15:0] drv_bus;
    logic        drv_act;

    int checks = 0;
    int errors = 0;

    exp_t q_w[$];
    exp_t q_n[$];
    logic [31:0] mdl_w  [int unsigned];
    logic [31:0] mdl_n  [int unsigned];
    logic [31:0] sram_w [int unsigned];
    logic [31:0] sram_n [int unsigned];

    always #5 clk = ~clk;

    ext_bus_responder_if #(.MEM_AW(AW_W)) bif_w ();
    ext_bus_responder_if #(.MEM_AW(AW_N)) bif_n ();

    ext_bus_responder #(.WAIT_CYCLES(W), .MEM_AW(AW_W)) dut_w (
        .clk(clk), .rst(rst), .bus(bif_w.slave), .OUT_busy(busy_w));
    ext_bus_responder #(.WAIT_CYCLES(W), .MEM_AW(AW_N)) dut_n (
        .clk(clk), .rst(rst), .bus(bif_n.slave), .OUT_busy(busy_n));

    assign bif_w.IN_bus       = drv_bus;
    assign bif_w.IN_busActive = drv_act;
    assign bif_n.IN_bus       = drv_bus;
    assign bif_n.IN_busActive = drv_act;

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] wm);
        logic [31:0] v = old;
        for (int b = 0; b < 4; b++) if (wm[b]) v[8*b +: 8] = d[8*b +: 8];
        return v;
    endfunction

    // External SRAM: one-cycle read latency, byte-masked writes
    always @(posedge clk) begin
        if (!bif_w.OUT_memCE) begin
            if (!bif_w.OUT_memWE)
                sram_w[32'(bif_w.OUT_memAddr)] = merge(sram_w.exists(32'(bif_w.OUT_memAddr)) ?
                    sram_w[32'(bif_w.OUT_memAddr)] : 32'h0, bif_w.OUT_memData, bif_w.OUT_memWM);
            else
                bif_w.IN_memData <= sram_w.exists(32'(bif_w.OUT_memAddr)) ? sram_w[32'(bif_w.OUT_memAddr)] : 32'h0;
        end
        if (!bif_n.OUT_memCE) begin
            if (!bif_n.OUT_memWE)
                sram_n[32'(bif_n.OUT_memAddr)] = merge(sram_n.exists(32'(bif_n.OUT_memAddr)) ?
                    sram_n[32'(bif_n.OUT_memAddr)] : 32'h0, bif_n.OUT_memData, bif_n.OUT_memWM);
            else
                bif_n.IN_memData <= sram_n.exists(32'(bif_n.OUT_memAddr)) ? sram_n[32'(bif_n.OUT_memAddr)] : 32'h0;
        end
    end

    // ---------------- reference model ----------------
    function automatic int unsigned word_of(int g, logic [30:0] ha);
        int unsigned aw = (g == 0) ? AW_W : AW_N;
        return (32'(ha) >> 1) & ((32'd1 << aw) - 32'd1);
    endfunction

    function automatic logic [31:0] mdl_get(int g, int unsigned a);
        if (g == 0) return mdl_w.exists(a) ? mdl_w[a] : 32'h0;
        return mdl_n.exists(a) ? mdl_n[a] : 32'h0;
    endfunction

    function automatic void push_exp(int g, exp_t e);
        if (g == 0) q_w.push_back(e);
        else        q_n.push_back(e);
    endfunction

    function automatic void model_write(int g, logic [30:0] ha, logic [15:0] h);
        exp_t e;
        logic [31:0] old;
        e.is_wr = 1'b1;
        e.addr  = word_of(g, ha);
        e.wm    = ha[0] ? 4'b1100 : 4'b0011;
        e.data  = ha[0] ? {h, 16'h0} : {16'h0, h};
        old     = mdl_get(g, e.addr);
        if (g == 0) mdl_w[e.addr] = ha[0] ? {h, old[15:0]} : {old[31:16], h};
        else        mdl_n[e.addr] = ha[0] ? {h, old[15:0]} : {old[31:16], h};
        push_exp(g, e);
    endfunction

    function automatic void model_read(int g, logic [30:0] ha);
        exp_t e;
        logic [31:0] w;
        w       = mdl_get(g, word_of(g, ha));
        e.is_wr = 1'b0;
        e.addr  = 0;
        e.wm    = 4'b0000;
        e.data  = {16'h0, ha[0] ? w[31:16] : w[15:0]};
        push_exp(g, e);
    endfunction

    // ---------------- monitor ----------------
    function automatic void observe(int g, bit is_wr, int unsigned addr, logic [3:0] wm,
                                    logic [31:0] data, logic [15:0] oen);
        exp_t e;
        checks++;
        if ((g == 0) ? (q_w.size() == 0) : (q_n.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_event dut%0d: got wr=%0d addr=%0h wm=%b data=%h, required no event",
                     g, is_wr, addr, wm, data);
            return;
        end
        e = (g == 0) ? q_w.pop_front() : q_n.pop_front();
        if (e.is_wr != is_wr || (is_wr && (e.addr != addr || e.wm != wm)) ||
            e.data != data || (!is_wr && oen != 16'hffff)) begin
            errors++;
            $display("FAIL event dut%0d: got wr=%0d addr=%0h wm=%b data=%h oen=%h, required wr=%0d addr=%0h wm=%b data=%h",
                     g, is_wr, addr, wm, data, oen, e.is_wr, e.addr, e.wm, e.data);
        end
    endfunction

    always @(negedge clk) begin
        if (!bif_w.OUT_memCE && !bif_w.OUT_memWE)
            observe(0, 1'b1, 32'(bif_w.OUT_memAddr), bif_w.OUT_memWM, bif_w.OUT_memData, bif_w.OUT_busOEn);
        if (bif_w.OUT_busOEn != 16'h0)
            observe(0, 1'b0, 0, 4'b0, {16'h0, bif_w.OUT_bus}, bif_w.OUT_busOEn);
        if (!bif_n.OUT_memCE && !bif_n.OUT_memWE)
            observe(1, 1'b1, 32'(bif_n.OUT_memAddr), bif_n.OUT_memWM, bif_n.OUT_memData, bif_n.OUT_busOEn);
        if (bif_n.OUT_busOEn != 16'h0)
            observe(1, 1'b0, 0, 4'b0, {16'h0, bif_n.OUT_bus}, bif_n.OUT_busOEn);
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bus"},   32'(bif_w.OUT_bus), 32'h0);
        chk({tag, "_oen"},   32'(bif_w.OUT_busOEn), 32'h0);
        chk({tag, "_wait"},  32'(bif_w.OUT_busWait), 32'h0);
        chk({tag, "_ce"},    32'(bif_w.OUT_memCE), 32'h1);
        chk({tag, "_we"},    32'(bif_w.OUT_memWE), 32'h1);
        chk({tag, "_wm"},    32'(bif_w.OUT_memWM), 32'h0);
        chk({tag, "_addr"},  32'(bif_w.OUT_memAddr), 32'h0);
        chk({tag, "_data"},  bif_w.OUT_memData, 32'h0);
        chk({tag, "_busy"},  32'(busy_w), 32'h0);
        chk({tag, "_woen"},  32'(bif_w.OUT_busWaitOEn), 32'h1);
        chk({tag, "_busyn"}, 32'(busy_n), 32'h0);
    endtask

    task automatic hdr(input logic [15:0] h0, input logic [15:0] h1);
        @(negedge clk); drv_act = 1'b1; drv_bus = h0;
        @(negedge clk); drv_bus = h1;
        @(negedge clk); drv_bus = 16'($urandom);
    endtask

    // Counts cycles of busWait high; returns at the negedge after it falls
    task automatic wait_phase();
        int n = 0;
        while (bif_w.OUT_busWait && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("wait_len", n, W);
        chk("wait_low_n", 32'(bif_n.OUT_busWait), 32'h0);
    endtask

    task automatic do_write(input logic [30:0] ha, input int n, input logic [15:0] d [8]);
        for (int i = 0; i < n; i++) begin
            model_write(0, 31'(ha + 31'(i)), d[i]);
            model_write(1, 31'(ha + 31'(i)), d[i]);
        end
        hdr({1'b1, ha[30:16]}, ha[15:0]);
        wait_phase();
        chk("wr_oen_off", 32'(bif_w.OUT_busOEn), 32'h0);
        for (int i = 0; i < n; i++) begin
            drv_bus = d[i];
            @(negedge clk);
        end
        drv_act = 1'b0; drv_bus = 16'($urandom);
        @(negedge clk);
        chk("wr_end_busy", 32'(busy_w), 32'h0);
    endtask

    task automatic do_read(input logic [30:0] ha, input int n);
        for (int i = 0; i < n; i++) begin
            model_read(0, 31'(ha + 31'(i)));
            model_read(1, 31'(ha + 31'(i)));
        end
        hdr({1'b0, ha[30:16]}, ha[15:0]);
        wait_phase();
        chk("rd_oen_first", 32'(bif_w.OUT_busOEn), 32'hffff);
        chk("rd_oen_first_n", 32'(bif_n.OUT_busOEn), 32'hffff);
        for (int i = 1; i < n; i++) @(negedge clk);
        drv_act = 1'b0;
        @(negedge clk);
        chk("rd_oen_off", 32'(bif_w.OUT_busOEn), 32'h0);
        chk("rd_end_busy", 32'(busy_w), 32'h0);
    endtask

    task automatic do_abort(input bit dir_wr);
        hdr({dir_wr, 15'h0}, 16'h0020);
        chk("abort_wait_hi", 32'(bif_w.OUT_busWait), 32'h1);
        drv_act = 1'b0;
        @(negedge clk);
        chk("abort_wait_lo", 32'(bif_w.OUT_busWait), 32'h0);
        chk("abort_busy", 32'(busy_w), 32'h0);
        chk("abort_busy_n", 32'(busy_n), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] dv [8];
        logic [30:0] ha;
        drv_act = 1'b0;
        drv_bus = 16'h0;
        #1 rst = 1'b0;
        #1 chk_reset_vals("rst0");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Write 4 halfwords from haddr 0x10
        dv[0] = 16'hA1A1; dv[1] = 16'hB2B2; dv[2] = 16'hC3C3; dv[3] = 16'hD4D4;
        for (int i = 4; i < 8; i++) dv[i] = 16'h0;
        do_write(31'h10, 4, dv);
        // Read 3 halfwords from haddr 0x11
        do_read(31'h11, 3);

        do_abort(1'b1);
        do_abort(1'b0);

        // Back-to-back write then read
        dv[0] = 16'h1234; dv[1] = 16'h5678;
        do_write(31'h40, 2, dv);
        do_read(31'h40, 2);

        // Reset in the middle of a read
        model_read(0, 31'h10); model_read(1, 31'h10);
        model_read(0, 31'h11); model_read(1, 31'h11);
        hdr(16'h0000, 16'h0010);
        wait_phase();
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_reset_vals("rst_mid");
        drv_act = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        do_read(31'h12, 2);

        // Address wrap: narrow SRAM word 15 high then word 0 low
        dv[0] = 16'hE5E5; dv[1] = 16'hF6F6;
        do_write(31'h1F, 2, dv);
        do_read(31'h1F, 2);
        // 31-bit halfword address wrap
        dv[0] = 16'h0F0F; dv[1] = 16'hF0F0;
        do_write(31'h7FFFFFFF, 2, dv);
        do_read(31'h7FFFFFFF, 2);

        // Randomized transfers
        for (int it = 0; it < 14; it++) begin
            int n;
            n  = int'($urandom_range(1, 6));
            ha = ($urandom_range(0, 3) == 0) ? 31'(31'h7FFFFFF8 + 31'($urandom_range(0, 7)))
                                             : 31'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 8; i++) dv[i] = 16'($urandom);
                do_write(ha, n, dv);
            end else begin
                do_read(ha, n);
            end
        end

        repeat (4) @(negedge clk);
        chk("drain_w", q_w.size(), 0);
        chk("drain_n", q_n.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ext_bus_responder.md
Name: ext_bus_responder

Overview:
- Target-side (responder) end of the 16-bit external memory bus that the SoC memory controller drives as initiator.
- Decodes the two-halfword address header and holds the initiator off with OUT_busWait.
- Write transfers: sinks streamed halfwords into a 32-bit word-wide synchronous SRAM port.
- Read transfers: streams halfwords from that SRAM port back onto the bus.
- Used as the off-chip memory model in system simulation and as the FPGA-side bridge.

Parameters:
- WAIT_CYCLES, 4: cycles OUT_busWait stays high after the header; legal range 2..15.
- MEM_AW, 16: word-address width of the SRAM port; halfword-address bits above MEM_AW are dropped, so addresses wrap.

Ports:
- clk  in  1  bus clock; the initiator's OUT_busClk.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- IN_bus  in  16  bus data from the initiator.
- IN_busActive  in  1  transfer-active strobe from the initiator.
- OUT_bus  out  16  bus data to the initiator.
- OUT_busOEn  out  16  per-bit output enable; 1 = this block drives the bit.
- OUT_busWait  out  1  wait/hold-off to the initiator.
- OUT_busWaitOEn  out  1  constant 1.
- OUT_memAddr  out  MEM_AW  SRAM word address.
- OUT_memData  out  32  SRAM write data.
- IN_memData  in  32  SRAM read data; valid one cycle after a read edge.
- OUT_memCE  out  1  SRAM chip enable, active-low.
- OUT_memWE  out  1  SRAM write enable, active-low.
- OUT_memWM  out  4  SRAM byte write mask; 1 = byte written.
- OUT_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (rst=0, asynchronous): state=IDLE, OUT_bus=0, OUT_busOEn=0, OUT_busWait=0, OUT_memCE=1, OUT_memWE=1, OUT_memWM=0, OUT_memAddr=0, OUT_memData=0, OUT_busy=0. Reset mid-transfer aborts with no further memory access.
- All outputs are registered; inputs are sampled on posedge clk.
- Halfword address: haddr[30:0] = {hdr0[14:0], hdr1[15:0]}.
- Word address: haddr[MEM_AW:1].
- haddr[0] selects the half of the word: 0 = bits [15:0], 1 = bits [31:16]. haddr increments by 1 per halfword.
- IDLE:
  - On IN_busActive=1: latch dir=IN_bus[15] (1 = write into memory) and hdr0; go to ADDR_LO.
- ADDR_LO:
  - Latch hdr1=IN_bus.
  - Set OUT_busWait=1, waitCnt=0.
  - Go to WAIT.
- WAIT:
  - waitCnt increments each cycle; OUT_busWait stays 1 for exactly WAIT_CYCLES cycles.
  - Read transfers only: SRAM reads are issued (CE=0, WE=1) early enough that the first halfword is registered on OUT_bus on the same edge that OUT_busWait falls.
  - On that same edge, OUT_busOEn becomes 16'hffff and the state goes to READ.
  - Write transfers: on the falling edge of OUT_busWait, go to WRITE; OUT_busOEn stays 0.
- READ:
  - One new halfword on OUT_bus per cycle, in order haddr, haddr+1, ...
  - One SRAM read is issued per cycle, one halfword ahead. Prefetch overrun when the transfer ends is harmless.
  - Upon sampling IN_busActive=0, on the same edge: OUT_busOEn=0, memory CE=1, state=IDLE.
- WRITE:
  - The first data halfword is sampled on the cycle after OUT_busWait was seen low.
  - A halfword is sampled every cycle while IN_busActive=1.
  - Each sample produces a registered write on the next edge: CE=0, WE=0, OUT_memAddr = word address.
    - haddr[0]=0: OUT_memWM=4'b0011, OUT_memData={16'h0, h}.
    - haddr[0]=1: OUT_memWM=4'b1100, OUT_memData={h, 16'h0}.
  - After each sample, haddr is incremented.
  - A cycle with no sample returns CE=1, WE=1, WM=0.
  - Upon sampling IN_busActive=0: no write for that cycle; state=IDLE.
- Abort: IN_busActive=0 sampled in ADDR_LO or WAIT goes to IDLE with OUT_busWait=0 and no memory write.
- Back-to-back transfers: a single IN_busActive=0 cycle between transfers is sufficient. IDLE accepts a new header on the very next cycle.
- Wrap: haddr increments modulo 2^31. The word address is truncated to MEM_AW bits.

Test Plan:
- Write: header 16'h8000/16'h0010, then 4 halfwords A1A1,B2B2,C3C3,D4D4, then busActive low.
  - Required: writes of word 8 WM=0011 then 1100, word 9 WM=0011 then 1100, with matching data.
  - No extra write after busActive low.
- Read: preload word 8=B2B2A1A1 and word 9=D4D4C3C3; header 16'h0000/16'h0011; hold busActive for 3 data cycles.
  - Required: busWait high exactly WAIT_CYCLES cycles.
  - Required: A1A1... no, starting at haddr 0x11 the bus shows B2B2, C3C3, D4D4 beginning on the cycle busWait falls, with OEn=ffff.
  - Required: OEn=0 the cycle after busActive is sampled low.
- Abort: drop busActive during WAIT.
  - Required: IDLE next cycle, busWait=0, OUT_memCE never 0 with WE=0.
- Back-to-back: a write of 2 halfwords, one idle cycle, then a read of 2 halfwords.
  - Required: both transfers complete correctly with no lost header.
- Reset: assert rst=0 mid-READ.
  - Required: all outputs take their reset values immediately, without waiting for a clock edge.
  - Required: after release, the next header is decoded correctly.
- Wrap with MEM_AW=4: write starting at haddr 0x1F, 2 halfwords.
  - Required: word 15 upper half is written, then word 0 lower half.
